// File: rtl/dmem_dump_unit.sv
// Data-memory readback engine: walks a fixed address window through a synchronous
// read port and streams every byte out on a valid/ready channel with a running checksum.
module dmem_dump_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int BASE   = 0,
   parameter int LEN    = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              finished,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
   localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_SEND,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W:0]   r_index;
   logic [ADDR_W-1:0] r_addrHold;
   logic [DATA_W-1:0] r_outData;
   logic              r_outLast;
   logic [DATA_W-1:0] r_checksum;
   logic [ADDR_W-1:0] w_curAddr;
   logic              w_startOk;
   logic              w_handshake;

   // The address wraps modulo 2^ADDR_W; only the index keeps its extra bit.
   assign w_curAddr   = BASE_A + r_index[ADDR_W-1:0];
   assign w_startOk   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_handshake = (r_state == S_SEND) && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_READ;
         S_READ:  w_next = S_WAIT;
         S_WAIT:  w_next = S_SEND;
         S_SEND:  if (out_ready) w_next = r_outLast ? S_DONE : S_READ;
         S_DONE:  if (start) w_next = S_READ;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_index    <= '0;
         r_addrHold <= '0;
         r_outData  <= '0;
         r_outLast  <= 1'b0;
         r_checksum <= '0;
      end else begin
         if (w_startOk) begin
            r_index    <= '0;
            r_checksum <= '0;
         end
         if (r_state == S_READ) begin
            r_addrHold <= w_curAddr;
         end
         // Read data arrives one cycle after rd_en, so capture it in WAIT.
         if (r_state == S_WAIT) begin
            r_outData <= rd_data;
            r_outLast <= (r_index == LAST_IDX);
         end
         if (w_handshake) begin
            r_checksum <= r_checksum + r_outData;
            r_index    <= r_index + (ADDR_W+1)'(1);
         end
      end
   end

   assign rd_en     = (r_state == S_READ);
   assign rd_addr   = rd_en ? w_curAddr : r_addrHold;
   assign out_data  = r_outData;
   assign out_valid = (r_state == S_SEND);
   assign out_last  = r_outLast;
   assign busy      = (r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_SEND);
   assign finished  = (r_state == S_DONE);
   assign checksum  = r_checksum;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Bench for dmem_dump_unit: five differently configured instances share one memory image
// and are checked every cycle against a transaction-level model of the dump.
module tb_dmem_dump_unit;

   localparam int NCFG = 5;

   function automatic int cfgBase(input int k);
      case (k)
         0:       return 0;
         1:       return 254;
         2:       return 16;
         3:       return 32;
         default: return 128;
      endcase
   endfunction

   function automatic int cfgLen(input int k);
      case (k)
         0:       return 4;
         1:       return 4;
         2:       return 2;
         3:       return 1;
         default: return 256;
      endcase
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [NCFG-1:0] start;
   logic [NCFG-1:0] outReady;
   logic [NCFG-1:0] rdEn;
   logic [NCFG-1:0] outValid;
   logic [NCFG-1:0] outLast;
   logic [NCFG-1:0] busy;
   logic [NCFG-1:0] finished;
   logic [7:0]      rdAddr   [NCFG];
   logic [7:0]      rdData   [NCFG];
   logic [7:0]      outData  [NCFG];
   logic [7:0]      checksum [NCFG];
   logic [7:0]      mem      [256];
   bit              randReady[NCFG];

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;

   // Model: which byte each instance owes next, when its read is due, and the running sum.
   bit         mActive  [NCFG];
   bit         mFinished[NCFG];
   int         mIdx     [NCFG];
   int         mReadAt  [NCFG];
   int         mAccept  [NCFG];
   int         mDoneOff [NCFG];
   logic [7:0] mSum     [NCFG];
   logic [7:0] rdOffLog [NCFG][$];
   logic [7:0] rdAddrLog[NCFG][$];
   logic [7:0] byteLog  [NCFG][$];
   logic [7:0] lastLog  [NCFG][$];

   for (genvar g = 0; g < NCFG; g++) begin : gDut
      dmem_dump_unit #(
         .ADDR_W(8),
         .DATA_W(8),
         .BASE  (cfgBase(g)),
         .LEN   (cfgLen(g))
      ) dut (
         .clk      (clk),
         .reset    (reset),
         .start    (start[g]),
         .rd_en    (rdEn[g]),
         .rd_addr  (rdAddr[g]),
         .rd_data  (rdData[g]),
         .out_data (outData[g]),
         .out_valid(outValid[g]),
         .out_ready(outReady[g]),
         .out_last (outLast[g]),
         .busy     (busy[g]),
         .finished (finished[g]),
         .checksum (checksum[g])
      );

      always @(posedge clk) begin
         if (rdEn[g]) rdData[g] <= mem[rdAddr[g]];
      end
   end

   task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         if (nFails <= 40)
            $display("[TB] FAIL %s cfg%0d: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] packQ(input logic [7:0] q[$]);
      logic [31:0] r = '0;
      foreach (q[i]) r = {r[23:0], q[i]};
      return r;
   endfunction

   // Single compare process: every negedge, every instance is held against the model.
   always @(negedge clk) begin
      logic [7:0] addr;
      bit         expValid;
      int         len;
      cyc++;
      for (int k = 0; k < NCFG; k++) begin
         len  = cfgLen(k);
         addr = 8'(cfgBase(k) + mIdx[k]);
         if (!reset) begin
            checkOutput("reset outputs", k,
                        {rdEn[k], rdAddr[k], outData[k], outValid[k], outLast[k], busy[k],
                         finished[k], checksum[k]}, 32'h0);
            mActive[k]   = 1'b0;
            mFinished[k] = 1'b0;
            mSum[k]      = 8'h00;
         end else if (mActive[k]) begin
            expValid = (cyc >= mReadAt[k] + 2);
            checkOutput("rd_en", k, rdEn[k], (cyc == mReadAt[k]));
            if (cyc == mReadAt[k]) begin
               checkOutput("rd_addr", k, rdAddr[k], addr);
               rdOffLog[k].push_back(8'(cyc - mAccept[k]));
               rdAddrLog[k].push_back(rdAddr[k]);
            end
            checkOutput("out_valid", k, outValid[k], expValid);
            checkOutput("busy", k, busy[k], 1);
            checkOutput("finished while busy", k, finished[k], 0);
            checkOutput("checksum running", k, checksum[k], mSum[k]);
            if (expValid) begin
               checkOutput("out_data", k, outData[k], mem[addr]);
               checkOutput("out_last", k, outLast[k], (mIdx[k] == len - 1));
               if (outReady[k]) begin
                  byteLog[k].push_back(outData[k]);
                  lastLog[k].push_back({7'd0, outLast[k]});
                  mSum[k] = mSum[k] + mem[addr];
                  mIdx[k]++;
                  if (mIdx[k] == len) begin
                     mActive[k]   = 1'b0;
                     mFinished[k] = 1'b1;
                     mDoneOff[k]  = cyc + 1 - mAccept[k];
                  end else begin
                     mReadAt[k] = cyc + 1;
                  end
               end
            end
         end else begin
            checkOutput("idle rd_en", k, rdEn[k], 0);
            checkOutput("idle out_valid", k, outValid[k], 0);
            checkOutput("idle busy", k, busy[k], 0);
            checkOutput("finished", k, finished[k], mFinished[k]);
            checkOutput("checksum held", k, checksum[k], mSum[k]);
            if (start[k]) begin
               mActive[k]   = 1'b1;
               mFinished[k] = 1'b0;
               mSum[k]      = 8'h00;
               mIdx[k]      = 0;
               mReadAt[k]   = cyc + 1;
               mAccept[k]   = cyc;
               rdOffLog[k].delete();
               rdAddrLog[k].delete();
               byteLog[k].delete();
               lastLog[k].delete();
            end
         end
      end
   end

   // Randomised backpressure for instances that opt in.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int k = 0; k < NCFG; k++)
            if (randReady[k]) outReady[k] = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic applyStimulus(input logic [NCFG-1:0] mask);
      @(posedge clk);
      #1 start = mask;
      @(posedge clk);
      #1 start = '0;
   endtask

   task automatic waitDone(input logic [NCFG-1:0] mask, input int budget);
      int n = 0;
      while (((finished & mask) != mask) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("dump completes within budget", 0, ((finished & mask) == mask), 1);
   endtask

   task automatic waitBytes(input int k, input int count, input int budget);
      int n = 0;
      while ((byteLog[k].size() < count) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("bytes arrive within budget", k, (byteLog[k].size() >= count), 1);
   endtask

   task automatic loadLiterals();
      mem[0]  = 8'h07;
      mem[1]  = 8'h05;
      mem[2]  = 8'h18;
      mem[3]  = 8'h01;
      mem[16] = 8'hF0;
      mem[17] = 8'h20;
   endtask

   initial begin
      int n;
      reset    = 1'b0;
      start    = '0;
      outReady = '1;
      for (int k = 0; k < NCFG; k++) randReady[k] = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      loadLiterals();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      $display("[TB] basic dump on all configurations, restart pulse during WAIT");
      applyStimulus('1);
      @(posedge clk);
      #1 start = '1;
      @(posedge clk);
      #1 start = '0;
      waitDone('1, 2000);
      checkOutput("cfg0 read offsets", 0, packQ(rdOffLog[0]), 32'h0104070A);
      checkOutput("cfg0 read addresses", 0, packQ(rdAddrLog[0]), 32'h00010203);
      checkOutput("cfg0 bytes", 0, packQ(byteLog[0]), 32'h07051801);
      checkOutput("cfg0 last flags", 0, packQ(lastLog[0]), 32'h00000001);
      checkOutput("cfg0 byte count", 0, byteLog[0].size(), 4);
      checkOutput("cfg0 checksum", 0, checksum[0], 8'h25);
      checkOutput("cfg0 done offset", 0, mDoneOff[0], 13);
      checkOutput("cfg1 wrapped addresses", 1, packQ(rdAddrLog[1]), 32'hFEFF0001);
      checkOutput("cfg1 byte count", 1, byteLog[1].size(), 4);
      checkOutput("cfg1 last flags", 1, packQ(lastLog[1]), 32'h00000001);
      checkOutput("cfg2 checksum overflow", 2, checksum[2], 8'h10);
      checkOutput("cfg3 byte count", 3, byteLog[3].size(), 1);
      checkOutput("cfg3 single byte is last", 3, packQ(lastLog[3]), 32'h00000001);
      checkOutput("cfg4 byte count", 4, byteLog[4].size(), 256);

      $display("[TB] backpressure on cfg0, rerun of cfg2 from DONE");
      applyStimulus(5'b00101);
      waitBytes(0, 1, 100);
      @(posedge clk);
      #1 outReady[0] = 1'b0;
      repeat (8) @(posedge clk);
      #1 outReady[0] = 1'b1;
      waitDone(5'b00101, 500);
      checkOutput("cfg0 bytes after stall", 0, packQ(byteLog[0]), 32'h07051801);
      checkOutput("cfg0 checksum after stall", 0, checksum[0], 8'h25);
      checkOutput("cfg2 rerun checksum", 2, checksum[2], 8'h10);

      $display("[TB] reset while cfg0 is sending its third byte");
      applyStimulus(5'b00001);
      waitBytes(0, 2, 100);
      @(posedge clk);
      #1 outReady[0] = 1'b0;
      n = 0;
      while (!outValid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("cfg0 reached SEND of byte 2", 0, outValid[0], 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("async reset out_valid", 0, outValid[0], 0);
      checkOutput("async reset busy", 0, busy[0], 0);
      checkOutput("async reset out_data", 0, outData[0], 0);
      checkOutput("async reset checksum", 0, checksum[0], 0);
      checkOutput("async reset rd_addr", 0, rdAddr[0], 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      outReady[0] = 1'b1;
      applyStimulus(5'b00001);
      waitDone(5'b00001, 500);
      checkOutput("cfg0 restart addresses", 0, packQ(rdAddrLog[0]), 32'h00010203);
      checkOutput("cfg0 restart checksum", 0, checksum[0], 8'h25);

      $display("[TB] randomised memory and backpressure");
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
         for (int k = 0; k < NCFG; k++) randReady[k] = 1'b1;
         applyStimulus('1);
         waitDone('1, 4000);
      end
      for (int k = 0; k < NCFG; k++) randReady[k] = 1'b0;
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
